// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: windowed ER/MED/WCE metric accumulator for approximate W-bit adders.
// Define ERRMON_BIAS_EN to build the signed bias accumulator; otherwise bias_sum is tied to 0.
module approx_adder_error_monitor #(
  parameter int W        = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             op_a,
  input  logic [W-1:0]             op_b,
  input  logic                     cin,
  input  logic [W:0]               approx_sum,
  output logic                     busy,
  output logic                     done,
  output logic                     res_valid,
  output logic [WIN_LOG2:0]        err_count,
  output logic [W:0]               max_ed,
  output logic [W+WIN_LOG2:0]      sum_ed,
  output logic [W+1+WIN_LOG2:0]    bias_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [1:0]            drn_q, drn_d;
  logic                  accept, clr;
  logic                  s1_v_q, s2_v_q, nz_q;
  logic [W:0]            exact_q, apx_q, ed_q, ed_d;
  logic [WIN_LOG2:0]     err_q;
  logic [W:0]            max_q;
  logic [W+WIN_LOG2:0]   sum_q;
  logic                  res_valid_q;

  assign in_ready  = state_q == RUN;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = state_q == DONE;
  assign res_valid = res_valid_q;
  assign accept    = in_valid & in_ready;
  assign clr       = (state_q == IDLE) & start;
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: begin
        state_d = start ? RUN : IDLE;
        cnt_d   = start ? '0 : cnt_q;
      end
      RUN: begin
        cnt_d   = accept ? cnt_q + 1'b1 : cnt_q;
        state_d = (accept && cnt_q == '1) ? DRAIN : RUN;
        drn_d   = '0;
      end
      DRAIN: begin
        drn_d   = drn_q + 1'b1;
        state_d = (drn_q == 2'd2) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      res_valid_q <= clr ? 1'b0 : (state_q == DONE) ? 1'b1 : res_valid_q;
    end
  end

  // Unsigned magnitude computed directly so no sign bit is left unused.
  assign ed_d = (apx_q >= exact_q) ? apx_q - exact_q : exact_q - apx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      exact_q <= '0;
      apx_q   <= '0;
      ed_q    <= '0;
      nz_q    <= 1'b0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
      if (accept) begin
        exact_q <= {1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin);
        apx_q   <= approx_sum;
      end
      if (s1_v_q) begin
        ed_q <= ed_d;
        nz_q <= ed_d != '0;
      end
      if (clr) begin
        err_q <= '0;
        max_q <= '0;
        sum_q <= '0;
      end else if (s2_v_q) begin
        err_q <= err_q + (WIN_LOG2+1)'(nz_q);
        max_q <= (ed_q > max_q) ? ed_q : max_q;
        sum_q <= sum_q + (W+1+WIN_LOG2)'(ed_q);
      end
    end
  end

`ifdef ERRMON_BIAS_EN
  logic [W+1:0]          diff_q;
  logic [W+1+WIN_LOG2:0] bias_q;
  assign bias_sum = bias_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      bias_q <= '0;
    end else begin
      if (s1_v_q) diff_q <= {1'b0, apx_q} - {1'b0, exact_q};
      if (clr) bias_q <= '0;
      else if (s2_v_q) bias_q <= bias_q + {{WIN_LOG2{diff_q[W+1]}}, diff_q};
    end
  end
`else
  assign bias_sum = '0;
`endif
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb_approx_adder_error_monitor: table-driven windows with a scoreboard of expected window metrics.
module tb_approx_adder_error_monitor;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, cin = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic [16:0] approx_sum = 0;
  logic in_ready, busy, done, res_valid;
  logic [2:0]  err_count;
  logic [16:0] max_ed;
  logic [18:0] sum_ed;
  logic [19:0] bias_sum;

  approx_adder_error_monitor #(.W(16), .WIN_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .approx_sum(approx_sum), .busy(busy),
    .done(done), .res_valid(res_valid), .err_count(err_count), .max_ed(max_ed),
    .sum_ed(sum_ed), .bias_sum(bias_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] a, b;
    logic [3:0]       c;
    logic [3:0][16:0] x;
    logic [3:0][1:0]  gap;
    logic [2:0]       err;
    logic [16:0]      mx;
    logic [18:0]      sm;
    logic [19:0]      bs;
  } vec_t;
  typedef struct {
    logic [2:0]  err;
    logic [16:0] mx;
    logic [18:0] sm;
    logic [19:0] bs;
  } res_t;

  res_t exp_q[$];
  vec_t tv[6];
  int checks = 0, errors = 0, dones = 0, nwin = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    res_t e;
    if (done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = exp_q.pop_front();
        chk("err_count", err_count, e.err);
        chk("max_ed", max_ed, e.mx);
        chk("sum_ed", sum_ed, e.sm);
        chk("bias_sum", bias_sum, e.bs);
      end
    end
  end

  task automatic put(input int k, input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic [16:0] x);
    tv[k].a[i] = a; tv[k].b[i] = b; tv[k].c[i] = c; tv[k].x[i] = x;
  endtask

  function automatic vec_t model(input vec_t v);
    longint ex, d, ed;
    v.err = 0; v.mx = 0; v.sm = 0; v.bs = 0;
    for (int i = 0; i < 4; i++) begin
      ex = longint'(v.a[i]) + longint'(v.b[i]) + longint'(v.c[i]);
      d  = longint'(v.x[i]) - ex;
      ed = d < 0 ? -d : d;
      if (ed != 0) v.err = v.err + 1;
      if (ed > longint'(v.mx)) v.mx = 17'(ed);
      v.sm = v.sm + 19'(ed);
      v.bs = v.bs + 20'(d);
    end
    return v;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] x);
    op_a = a; op_b = b; cin = c; approx_sum = x; in_valid = 1;
    chk("in_ready_run", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_start;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_res_valid", res_valid, 0);
    chk("start_clear", {err_count, max_ed, sum_ed, bias_sum}, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit midstart, input bit hold);
    res_t e;
    int n;
    e.err = v.err; e.mx = v.mx; e.sm = v.sm; e.bs = v.bs;
`ifndef ERRMON_BIAS_EN
    e.bs = 0;
`endif
    exp_q.push_back(e);
    nwin++;
    do_start();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(v.gap[i]); g++) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      if (midstart && i == 2) begin
        in_valid = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("midstart_busy", busy, 1);
      end
      drive(v.a[i], v.b[i], v.c[i], v.x[i]);
      if (!hold) in_valid = 0;
    end
    chk("ready_after_last", in_ready, 0);
    chk("busy_drain", busy, 1);
    n = 1;
    while (n <= 10) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_latency", n, 4);
    @(posedge clk); #1;
    in_valid = 0;
    chk("res_valid_after", res_valid, 1);
    chk("busy_after", busy, 0);
    chk("done_once", done, 0);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk("res_valid_held", res_valid, 1);
      chk("held_metrics", {err_count, max_ed, sum_ed}, {v.err, v.mx, v.sm});
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) tv[k].gap = '0;
    put(0, 0, 16'h00FF, 16'h0001, 0, 17'h00100);
    put(0, 1, 16'h1234, 16'h1111, 1, 17'h02346);
    put(0, 2, 16'hFFFF, 16'hFFFF, 1, 17'h1FFFF);
    put(0, 3, 16'h0000, 16'h0000, 0, 17'h00000);
    tv[0].err = 0; tv[0].mx = 0; tv[0].sm = 0; tv[0].bs = 0;
    put(1, 0, 16'h0003, 16'h0001, 0, 17'h00000);
    put(1, 1, 16'h0005, 16'h0003, 0, 17'h00004);
    put(1, 2, 16'h0001, 16'h0001, 0, 17'h00002);
    put(1, 3, 16'h0007, 16'h0008, 1, 17'h00010);
    tv[1].err = 2; tv[1].mx = 4; tv[1].sm = 8; tv[1].bs = 20'hFFFF8;
    for (int i = 0; i < 4; i++) put(2, i, 16'hFFFF, 16'h0001, 0, 17'h10001);
    tv[2].err = 4; tv[2].mx = 1; tv[2].sm = 4; tv[2].bs = 20'h00004;
    for (int k = 3; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic [16:0] ex;
        tv[k].a[i] = 16'($urandom); tv[k].b[i] = 16'($urandom); tv[k].c[i] = 1'($urandom);
        ex = 17'(tv[k].a[i]) + 17'(tv[k].b[i]) + 17'(tv[k].c[i]);
        tv[k].x[i] = (k == 4) ? 17'($urandom) : ex ^ 17'($urandom_range(0, 15));
      end
      tv[k] = model(tv[k]);
    end
    tv[5].gap[1] = 2; tv[5].gap[3] = 1;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_outputs", {in_ready, busy, done, res_valid, err_count, max_ed, sum_ed, bias_sum}, 0);

    for (int k = 0; k < 6; k++) run_vec(tv[k], 0, 0);
    run_vec(tv[1], 1, 1);

    do_start();
    drive(16'h0003, 16'h0001, 0, 17'h00000);
    drive(16'h0005, 16'h0003, 0, 17'h00004);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 chk("pre_reset_acc", sum_ed, 8);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_outputs", {in_ready, busy, done, res_valid, err_count, max_ed, sum_ed, bias_sum}, 0);
    repeat (8) @(posedge clk);
    #1 chk("midrst_no_done", dones, nwin);
    run_vec(tv[2], 0, 0);

    chk("done_count", dones, nwin);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
